// File: rtl/seven_segment_scan_capture.sv
// seven_segment_scan_capture
// Receive side of the seven-segment display driver: samples the multiplexed
// segment/anode lines, waits for each digit to settle, decodes it and
// rebuilds the displayed BCD word (digit 0 in bits [3:0]) with frame status.
// Build option: define SEVEN_SEG_CAPTURE_CHANGE_EN to publish a completed
// frame only when its word differs from the word already on o_BCD_Num.
module seven_segment_scan_capture #(
  parameter int DIGITS         = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  input  logic [6:0]          i_Segments,
  input  logic [DIGITS-1:0]   i_Anodes,
  output logic [4*DIGITS-1:0] o_BCD_Num,
  output logic                o_Frame_Valid,
  output logic                o_Bad_Pattern,
  output logic                o_Anode_Error,
  output logic                o_Stalled
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]        SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic [1:0] {IDLE, FILLING, STALLED, DONE} state_t;

  logic [6:0]          seg_meta, seg_sync, seg_lit;
  logic [DIGITS-1:0]   an_meta, an_sync, an_sel;
  logic [DIGITS+6:0]   scan_now, scan_prev;
  logic [SW-1:0]       settle_cnt;
  logic                settle_event, capture_one, capture_multi;
  logic [3:0]          dec_nib;
  logic                dec_bad;
  logic [4*DIGITS-1:0] word_asm;
  logic [DIGITS-1:0]   seen, seen_next;
  logic [TW-1:0]       stall_cnt;
  state_t              state;
`ifdef SEVEN_SEG_CAPTURE_CHANGE_EN
  logic                have_frame;
`endif

  // Two-flop synchroniser for the asynchronous display lines, reset to "all off".
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      seg_meta <= SEG_IDLE;
      seg_sync <= SEG_IDLE;
      an_meta  <= AN_IDLE;
      an_sync  <= AN_IDLE;
    end else begin
      // NOTE: non-blocking keeps this a two-stage pipeline; blocking would collapse it into one flop.
      seg_meta <= i_Segments;
      seg_sync <= seg_meta;
      an_meta  <= i_Anodes;
      an_sync  <= an_meta;
    end
  end

  // Polarity normalisation: 1 = segment lit / digit selected.
  assign seg_lit  = SEG_ACTIVE_LOW ? ~seg_sync : seg_sync;
  assign an_sel   = AN_ACTIVE_LOW  ? ~an_sync  : an_sync;
  assign scan_now = {seg_lit, an_sel};

  // Settle counter: restarts on any change, saturates once the lines have been stable long enough.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      scan_prev  <= '0;
      settle_cnt <= '0;
    end else begin
      scan_prev <= scan_now;
      if (scan_now != scan_prev)       settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Single event per stable period: the cycle on which the count reaches SETTLE_CYCLES.
  assign settle_event  = (scan_now == scan_prev) && (settle_cnt == SETTLE_LAST);
  assign capture_one   = settle_event && $onehot(an_sel);
  assign capture_multi = settle_event && (an_sel != '0) && !$onehot(an_sel);
  assign seen_next     = seen | an_sel;

  // Segment pattern to BCD nibble; blank shows as F, anything unknown as E.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    dec_nib = 4'hE;
    dec_bad = 1'b1;
    case (seg_lit)
      7'h3F: begin dec_nib = 4'h0; dec_bad = 1'b0; end
      7'h06: begin dec_nib = 4'h1; dec_bad = 1'b0; end
      7'h5B: begin dec_nib = 4'h2; dec_bad = 1'b0; end
      7'h4F: begin dec_nib = 4'h3; dec_bad = 1'b0; end
      7'h66: begin dec_nib = 4'h4; dec_bad = 1'b0; end
      7'h6D: begin dec_nib = 4'h5; dec_bad = 1'b0; end
      7'h7D: begin dec_nib = 4'h6; dec_bad = 1'b0; end
      7'h07: begin dec_nib = 4'h7; dec_bad = 1'b0; end
      7'h7F: begin dec_nib = 4'h8; dec_bad = 1'b0; end
      7'h6F: begin dec_nib = 4'h9; dec_bad = 1'b0; end
      7'h00: begin dec_nib = 4'hF; dec_bad = 1'b0; end
      default: ;
    endcase
  end

  // Digit slots of the frame under assembly.
  // NOTE: no reset needed -- a word is only published after every slot has been rewritten in that frame.
  always_ff @(posedge i_Clk) begin
    if (capture_one) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (an_sel[k]) word_asm[4*k +: 4] <= dec_nib;
      end
    end
  end

  // Frame tracking, stall timer and registered status outputs.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= IDLE;
      seen          <= '0;
      stall_cnt     <= '0;
      o_BCD_Num     <= '0;
      o_Frame_Valid <= 1'b0;
      o_Bad_Pattern <= 1'b0;
      o_Anode_Error <= 1'b0;
      o_Stalled     <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_CHANGE_EN
      have_frame    <= 1'b0;
`endif
    end else begin
      o_Frame_Valid <= 1'b0;
      o_Anode_Error <= capture_multi;

      if (capture_one) begin
        stall_cnt <= '0;
        o_Stalled <= 1'b0;
      end else if (stall_cnt != TIMEOUT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      case (state)
        DONE: begin
`ifdef SEVEN_SEG_CAPTURE_CHANGE_EN
          if (!have_frame || (word_asm != o_BCD_Num)) begin
            o_BCD_Num     <= word_asm;
            o_Frame_Valid <= 1'b1;
          end
          have_frame <= 1'b1;
`else
          o_BCD_Num     <= word_asm;
          o_Frame_Valid <= 1'b1;
`endif
          seen  <= '0;
          state <= IDLE;
        end
        default: begin
          if (capture_one) begin
            // The first capture of a frame restarts the sticky bad-pattern flag.
            o_Bad_Pattern <= (seen == '0) ? dec_bad : (o_Bad_Pattern | dec_bad);
            seen          <= seen_next;
            state         <= (&seen_next) ? DONE : FILLING;
          end else if (stall_cnt == TIMEOUT_LAST) begin
            seen      <= '0;
            o_Stalled <= 1'b1;
            state     <= STALLED;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_capture.sv
// tb_seven_segment_scan_capture
// Scenario tasks drive active-low scans of the display lines; expected words
// and pulse counts come from a frame-level model of the display.
`timescale 1ns/1ps
module tb_seven_segment_scan_capture;

  localparam int N    = 8;
  localparam int HOLD = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    segs;
  logic [N-1:0]  anodes;
  logic [4*N-1:0] bcd;
  logic          fv, badp, aerr, stalled;

  int n_total = 0;
  int n_bad   = 0;
  int fv_count = 0;
  int ae_count = 0;
  int order [N];

  // Frame-level model state: last published word and whether one exists since reset.
  logic [31:0] mdl_bcd  = '0;
  bit          mdl_have = 1'b0;

  seven_segment_scan_capture dut (
    .i_Clk        (clk),
    .i_Reset_n    (rst_n),
    .i_Segments   (segs),
    .i_Anodes     (anodes),
    .o_BCD_Num    (bcd),
    .o_Frame_Valid(fv),
    .o_Bad_Pattern(badp),
    .o_Anode_Error(aerr),
    .o_Stalled    (stalled)
  );

  always #100 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (fv)   fv_count++;
    if (aerr) ae_count++;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
      4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
      4'h9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int k);
    return 4'((w >> (4*k)) & 32'hF);
  endfunction

  // Word the display should yield: bad digits read back as E.
  function automatic logic [31:0] exp_word(input logic [31:0] w, input logic [7:0] badm);
    logic [31:0] r = 0;
    for (int k = 0; k < N; k++)
      r = r + ((badm[k] ? 32'd14 : 32'(nib_of(w, k))) << (4*k));
    return r;
  endfunction

  task automatic model_frame(input logic [31:0] w, output int pulse);
`ifdef SEVEN_SEG_CAPTURE_CHANGE_EN
    pulse = (!mdl_have || w != mdl_bcd) ? 1 : 0;
`else
    pulse = 1;
`endif
    if (pulse == 1) mdl_bcd = w;
    mdl_have = 1'b1;
  endtask

  task automatic idle_lines();
    anodes = '1;
    segs   = '1;
  endtask

  task automatic show(input int k, input logic [6:0] lit);
    @(negedge clk);
    anodes = ~(8'd1 << k);
    segs   = ~lit;
    repeat (HOLD - 1) @(negedge clk);
    idle_lines();
    repeat (2) @(negedge clk);
  endtask

  task automatic natural_order();
    for (int i = 0; i < N; i++) order[i] = i;
  endtask

  task automatic drive_digits(input logic [31:0] w, input logic [7:0] badm, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int k;
      k = order[i];
      show(k, badm[k] ? 7'h49 : seg_of(nib_of(w, k)));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_lines();
    repeat (4) @(negedge clk);
    n_total++; if (bcd !== 32'h0) begin n_bad++; $display("FAIL reset_bcd got=%h want=0", bcd); end
    n_total++; if ({fv, badp, aerr, stalled} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got=%b want=0000", {fv, badp, aerr, stalled}); end
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    int rise = 0;
    int fv0  = fv_count;
    for (int i = 1; i <= 50020 && rise == 0; i++) begin
      @(negedge clk);
      if (stalled) rise = i;
    end
    n_total++; if (rise != 50000) begin n_bad++; $display("FAIL stall_cycle got=%0d want=50000", rise); end
    n_total++; if ({bcd, badp, aerr} !== 34'h0 || fv_count != fv0) begin n_bad++; $display("FAIL stall_others bcd=%h bad=%b aerr=%b fv=%0d want all 0", bcd, badp, aerr, fv_count - fv0); end
  endtask

  task automatic test_frame();
    int fv0 = fv_count;
    int p;
    natural_order();
    drive_digits(32'h12345678, 8'h00, 0, N - 1);
    model_frame(32'h12345678, p);
    n_total++; if (fv_count - fv0 != p) begin n_bad++; $display("FAIL frame_pulse got=%0d want=%0d", fv_count - fv0, p); end
    n_total++; if (bcd !== mdl_bcd) begin n_bad++; $display("FAIL frame_word got=%h want=%h", bcd, mdl_bcd); end
    n_total++; if (badp !== 1'b0 || stalled !== 1'b0) begin n_bad++; $display("FAIL frame_status bad=%b stalled=%b want 0 0", badp, stalled); end
  endtask

  task automatic test_bad_pattern();
    int fv0 = fv_count;
    int p;
    natural_order();
    drive_digits(32'h12345678, 8'b0000_1000, 0, N - 1);
    model_frame(exp_word(32'h12345678, 8'b0000_1000), p);
    n_total++; if (fv_count - fv0 != p) begin n_bad++; $display("FAIL bad_pulse got=%0d want=%0d", fv_count - fv0, p); end
    n_total++; if (bcd !== mdl_bcd) begin n_bad++; $display("FAIL bad_word got=%h want=%h", bcd, mdl_bcd); end
    n_total++; if (badp !== 1'b1) begin n_bad++; $display("FAIL bad_sticky got=%b want=1", badp); end
    fv0 = fv_count;
    drive_digits(32'h87654321, 8'h00, 0, 0);
    n_total++; if (badp !== 1'b0) begin n_bad++; $display("FAIL bad_clear got=%b want=0", badp); end
    drive_digits(32'h87654321, 8'h00, 1, N - 1);
    model_frame(32'h87654321, p);
    n_total++; if (fv_count - fv0 != p || bcd !== mdl_bcd) begin n_bad++; $display("FAIL bad_next_frame pulses=%0d word=%h want %0d %h", fv_count - fv0, bcd, p, mdl_bcd); end
  endtask

  task automatic test_anode_error();
    int fv0 = fv_count;
    int ae0 = ae_count;
    int p;
    natural_order();
    drive_digits(32'h76543210, 8'h00, 0, 1);
    @(negedge clk);
    anodes = 8'b1111_1100;
    segs   = ~seg_of(4'h8);
    repeat (HOLD) @(negedge clk);
    idle_lines();
    repeat (2) @(negedge clk);
    n_total++; if (ae_count - ae0 != 1) begin n_bad++; $display("FAIL anode_err_pulses got=%0d want=1", ae_count - ae0); end
    n_total++; if (fv_count != fv0) begin n_bad++; $display("FAIL anode_err_no_frame got=%0d want=0", fv_count - fv0); end
    drive_digits(32'h76543210, 8'h00, 2, N - 1);
    model_frame(32'h76543210, p);
    n_total++; if (fv_count - fv0 != p || bcd !== mdl_bcd) begin n_bad++; $display("FAIL anode_err_frame pulses=%0d word=%h want %0d %h", fv_count - fv0, bcd, p, mdl_bcd); end
  endtask

  task automatic test_glitch();
    int fv0 = fv_count;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      anodes = ~(8'd1 << k);
      for (int t = 0; t < 10; t++) begin
        segs = ~seg_of(4'h1);
        repeat (2) @(negedge clk);
        segs = ~seg_of(4'h7);
        repeat (2) @(negedge clk);
      end
      idle_lines();
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_total++; if (fv_count != fv0) begin n_bad++; $display("FAIL glitch_no_frame got=%0d want=0", fv_count - fv0); end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      logic [31:0] w = 0;
      logic [7:0]  badm;
      int fv0, p, j, tmp, idx;
      natural_order();
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int k = 0; k < N; k++) begin
        idx = $urandom_range(0, 10);
        w = w + ((idx == 10 ? 32'd15 : 32'(idx)) << (4*k));
      end
      badm = ($urandom_range(0, 3) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'h00;
      fv0 = fv_count;
      // Earlier stale value on the first-scanned digit must be overwritten.
      if ($urandom_range(0, 1) == 1) show(order[0], seg_of(4'($urandom_range(0, 9))));
      drive_digits(w, badm, 0, N - 1);
      model_frame(exp_word(w, badm), p);
      n_total++; if (fv_count - fv0 != p) begin n_bad++; $display("FAIL rand_pulse[%0d] got=%0d want=%0d", f, fv_count - fv0, p); end
      n_total++; if (bcd !== mdl_bcd) begin n_bad++; $display("FAIL rand_word[%0d] got=%h want=%h", f, bcd, mdl_bcd); end
      n_total++; if (badp !== (badm != 8'h00)) begin n_bad++; $display("FAIL rand_bad[%0d] got=%b want=%b", f, badp, badm != 8'h00); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3] = '{32'h12345678, 32'h00000000, 32'h00000000};
    int fv0, p;
    natural_order();
    for (int f = 0; f < 3; f++) begin
      fv0 = fv_count;
      drive_digits(words[f], 8'h00, 0, N - 1);
      model_frame(words[f], p);
      n_total++; if (fv_count - fv0 != p) begin n_bad++; $display("FAIL repeat_pulse[%0d] got=%0d want=%0d", f, fv_count - fv0, p); end
      n_total++; if (bcd !== mdl_bcd) begin n_bad++; $display("FAIL repeat_word[%0d] got=%h want=%h", f, bcd, mdl_bcd); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int fv0, p;
    natural_order();
    drive_digits(32'h99999999, 8'h00, 0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    mdl_bcd  = '0;
    mdl_have = 1'b0;
    n_total++; if ({bcd, fv, badp, aerr, stalled} !== 36'h0) begin n_bad++; $display("FAIL midreset_zero bcd=%h flags=%b want 0", bcd, {fv, badp, aerr, stalled}); end
    rst_n = 1'b1;
    fv0 = fv_count;
    drive_digits(32'h00000000, 8'h00, 5, N - 1);
    n_total++; if (fv_count != fv0) begin n_bad++; $display("FAIL midreset_no_stale got=%0d want=0", fv_count - fv0); end
    drive_digits(32'h00000000, 8'h00, 0, 4);
    model_frame(32'h00000000, p);
    n_total++; if (fv_count - fv0 != p || bcd !== mdl_bcd) begin n_bad++; $display("FAIL midreset_first_frame pulses=%0d word=%h want %0d %h", fv_count - fv0, bcd, p, mdl_bcd); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_frame();
    test_bad_pattern();
    test_anode_error();
    test_glitch();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
